// File: rtl/cdb_wb_arbiter.sv
// Writeback scheduler: per-unit completion buffers feeding one registered CDB / PRF write / ROB-done port.
//   cdb_wb_fifo    - small circular buffer with head/tail pointers and an occupancy count.
//   cdb_wb_arbiter - top: clk, rst (async, active-low), squash_i, src_vld_i/src_rdy_o/src_*_i per source,
//                    cdb_vld_o/cdb_tag_o/cdb_value_o, preg_wr_en_o, rob_done_o/rob_idx_o, grant_o (one-hot).

// Generic FIFO: DEPTH entries of W bits, head entry visible combinationally on rd_dat.
// Latency: a push at edge N is readable after edge N; count is registered.
// Backpressure: caller must not push when count == DEPTH nor pop when count == 0; flush empties it.
module cdb_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wr_dat,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[tail] <= wr_dat;
    end

    assign rd_dat = mem[head];
endmodule

// Round-robin writeback arbiter: one buffered result per cycle onto a registered CDB.
// Latency: 2 cycles from accept to CDB (buffer write, then output register).
// Backpressure: src_rdy_o[i] drops when buffer i is full (registered count, no pass-through); squash empties all.
module cdb_wb_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int BUF_DEPTH = 2,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int ZERO_TAG  = 31
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           squash_i,
    input  logic [NUM_SRC-1:0]             src_vld_i,
    output logic [NUM_SRC-1:0]             src_rdy_o,
    input  logic [NUM_SRC*PRF_IDX_W-1:0]   src_tag_i,
    input  logic [NUM_SRC*64-1:0]          src_value_i,
    input  logic [NUM_SRC*ROB_IDX_W-1:0]   src_rob_idx_i,
    output logic                           cdb_vld_o,
    output logic [PRF_IDX_W-1:0]           cdb_tag_o,
    output logic [63:0]                    cdb_value_o,
    output logic                           preg_wr_en_o,
    output logic                           rob_done_o,
    output logic [ROB_IDX_W-1:0]           rob_idx_o,
    output logic [NUM_SRC-1:0]             grant_o
);
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [PRF_IDX_W-1:0] ZTAG = PRF_IDX_W'(ZERO_TAG);

    typedef struct packed {
        logic [PRF_IDX_W-1:0] tag;
        logic [63:0]          value;
        logic [ROB_IDX_W-1:0] rob_idx;
    } entry_t;

    entry_t             wr_ent   [NUM_SRC];
    entry_t             head_ent [NUM_SRC];
    logic [CNT_W-1:0]   count    [NUM_SRC];
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] empty;

    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    rr_nxt;
    logic [RR_W-1:0]    cand;
    logic [RR_W-1:0]    win_idx;
    logic               win_vld;

    logic               nxt_vld;
    logic [PRF_IDX_W-1:0] nxt_tag;
    logic [63:0]        nxt_value;
    logic [ROB_IDX_W-1:0] nxt_rob;
    logic [NUM_SRC-1:0] nxt_grant;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign wr_ent[g] = '{tag:     src_tag_i[g*PRF_IDX_W +: PRF_IDX_W],
                             value:   src_value_i[g*64 +: 64],
                             rob_idx: src_rob_idx_i[g*ROB_IDX_W +: ROB_IDX_W]};
        assign src_rdy_o[g] = count[g] < CNT_W'(BUF_DEPTH);
        assign empty[g]     = count[g] == '0;
        // Squash wins over both enqueue and dequeue.
        assign push[g] = src_vld_i[g] && src_rdy_o[g] && !squash_i;
        assign pop[g]  = win_vld && (win_idx == RR_W'(g)) && !squash_i;

        cdb_wb_fifo #(
            .W     ($bits(entry_t)),
            .DEPTH (BUF_DEPTH)
        ) u_buf (
            .clk    (clk),
            .rst    (rst),
            .flush  (squash_i),
            .push   (push[g]),
            .pop    (pop[g]),
            .wr_dat (wr_ent[g]),
            .rd_dat (head_ent[g]),
            .count  (count[g])
        );
    end

    // First non-empty buffer at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = RR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!win_vld && !empty[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        nxt_vld   = 1'b0;
        nxt_tag   = ZTAG;
        nxt_value = '0;
        nxt_rob   = '0;
        nxt_grant = '0;
        rr_nxt    = rr_ptr;
        if (win_vld && !squash_i) begin
            nxt_vld            = 1'b1;
            nxt_tag            = head_ent[win_idx].tag;
            nxt_value          = head_ent[win_idx].value;
            nxt_rob            = head_ent[win_idx].rob_idx;
            nxt_grant[win_idx] = 1'b1;
            rr_nxt             = (win_idx == RR_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            cdb_vld_o   <= 1'b0;
            rob_done_o  <= 1'b0;
            cdb_tag_o   <= ZTAG;
            cdb_value_o <= '0;
            rob_idx_o   <= '0;
            grant_o     <= '0;
        end else begin
            rr_ptr      <= rr_nxt;
            cdb_vld_o   <= nxt_vld;
            rob_done_o  <= nxt_vld;
            cdb_tag_o   <= nxt_tag;
            cdb_value_o <= nxt_value;
            rob_idx_o   <= nxt_rob;
            grant_o     <= nxt_grant;
        end
    end

    // The zero tag still completes in the ROB but must never reach the register file.
    assign preg_wr_en_o = cdb_vld_o && (cdb_tag_o != ZTAG);
endmodule

// File: doc/cdb_wb_arbiter.md
Name: cdb_wb_arbiter

Overview:
- Writeback scheduler between the execution units (int ALU, multiplier, load unit) and the single CDB / physical register file write port.
- Each source has a small completion buffer with a valid/ready handshake. A round-robin arbiter picks one buffered result per cycle and drives it onto a registered CDB, PRF write port and ROB-done port.
- Replaces fixed-priority CDB muxing inside the FU top so that no unit's result is ever dropped.

Parameters:
- NUM_SRC, 3, number of completion sources (index 0 = int ALU, 1 = mult, 2 = load).
- BUF_DEPTH, 2, entries per source buffer (power of two, >= 2).
- PRF_IDX_W, 6, physical register tag width.
- ROB_IDX_W, 5, ROB index width.
- ZERO_TAG, 31, physical tag that must never be written.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- squash_i  in  1  branch-mispredict flush; synchronous.
- src_vld_i  in  NUM_SRC  per-source result valid.
- src_rdy_o  out  NUM_SRC  per-source buffer can accept.
- src_tag_i  in  NUM_SRC*PRF_IDX_W  dest tags, source i at [i*PRF_IDX_W +: PRF_IDX_W].
- src_value_i  in  NUM_SRC*64  result values, packed the same way.
- src_rob_idx_i  in  NUM_SRC*ROB_IDX_W  ROB indices, packed the same way.
- cdb_vld_o  out  1  CDB broadcast valid.
- cdb_tag_o  out  PRF_IDX_W  broadcast tag.
- cdb_value_o  out  64  broadcast value.
- preg_wr_en_o  out  1  PRF write enable.
- rob_done_o  out  1  ROB completion strobe.
- rob_idx_o  out  ROB_IDX_W  completing ROB entry.
- grant_o  out  NUM_SRC  one-hot, source whose result is on the CDB this cycle (debug/perf).

Behaviour:
- Reset (rst=0, asynchronous): all buffers empty, rr_ptr=0.
  - cdb_vld_o=0, cdb_tag_o=ZERO_TAG, cdb_value_o=0, preg_wr_en_o=0, rob_done_o=0, rob_idx_o=0, grant_o=0.
  - src_rdy_o is all-ones while in reset and after release.
- Buffers: one FIFO per source, BUF_DEPTH entries {tag, value, rob_idx}, with head/tail pointers that wrap and a count register.
  - src_rdy_o[i] = (count_i < BUF_DEPTH), taken from registered count only; there is no same-cycle pass-through. A full buffer shows rdy=0 even in a cycle where it is dequeued.
- Enqueue: on a clock edge with src_vld_i[i] && src_rdy_o[i]. A vld with rdy=0 is ignored; the source must hold its result.
- Arbitration (combinational, every cycle):
  - Search non-empty buffers starting at rr_ptr, ascending modulo NUM_SRC. The first hit wins and its head is dequeued at the edge.
  - After a grant, rr_ptr <= winner+1 (mod NUM_SRC). With no grant, rr_ptr holds.
- Output register (updated every edge):
  - cdb_vld_o/rob_done_o <= any grant.
  - tag/value/rob_idx <= winner's head entry.
  - grant_o <= one-hot winner.
  - With no grant: vld=0, tag=ZERO_TAG, value=0, rob_idx=0, grant=0.
- preg_wr_en_o = cdb_vld_o && (cdb_tag_o != ZERO_TAG). A ZERO_TAG entry still pulses rob_done_o and cdb_vld_o.
- Latency: a result accepted at edge N appears on the CDB after edge N+1 at the earliest (2 cycles input to output).
- Throughput: 1 result/cycle total. With all sources continuously backlogged, each source gets exactly 1 grant per NUM_SRC cycles.
- Simultaneous enqueue and dequeue on the same buffer: count unchanged, both pointers advance.
- squash_i=1 at an edge:
  - All buffers are emptied and any enqueue in that cycle is dropped.
  - Output register is cleared to the idle values; rr_ptr holds.
  - src_rdy_o is all-ones the next cycle.
  - squash_i overrides arbitration.

Test Plan:
- Reset mid-traffic:
  - Stimulus: fill ALU buffer with 2 entries, then assert rst=0 asynchronously between edges.
  - Required: cdb_vld_o drops to 0 immediately, src_rdy_o=3'b111, and no stale result appears after release.
- Single source:
  - Stimulus: ALU sends tag 5, value 0x1234, rob 3 at edge 0.
  - Required: after edge 1, cdb_vld_o=1, tag=5, value=0x1234, rob_idx_o=3, preg_wr_en_o=1, grant_o=3'b001; after edge 2, cdb_vld_o=0.
- Round-robin fairness:
  - Stimulus: all 3 sources keep 2 entries each from edge 0.
  - Required: grant_o sequence 001,010,100,001,010,100; 6 results in 6 consecutive cycles; no loss.
- Backpressure:
  - Stimulus: mult pushes 3 results back-to-back while ALU is continuously busy.
  - Required: src_rdy_o[1]=0 after the second accept; the third result is accepted only after a mult grant; FIFO order is preserved.
- Zero tag:
  - Stimulus: load result with tag=31, rob 7.
  - Required: cdb_vld_o=1, rob_done_o=1, rob_idx_o=7, preg_wr_en_o=0.
- Squash:
  - Stimulus: buffers hold 4 entries total; squash_i=1 for one cycle with a concurrent ALU vld.
  - Required: the next cycle cdb_vld_o=0 and all counts=0; the concurrent ALU entry is never broadcast; rr_ptr is unchanged.
